reg_file_clr: RTL and testbench

Parametrised successor to the RV32I register file: one write port and two asynchronous read ports, with the x0-is-zero rule enforced in hardware. Adds an optional same-cycle write-to-read bypass, a parametrised debug tap (default a0/x10), and a post-reset clear sequencer that zeroes every entry one per cycle while asserting `busy`. It sits in the decode stage between the instruction decoder (addresses) and the ALU/result mux (data); the top level exports the tap to the display logic.

---
 rtl/rf_pkg.sv | 12 +
 rtl/reg_file_clr_if.sv | 29 ++
 rtl/rf_read_port.sv | 29 ++
 rtl/reg_file_clr.sv | 116 +++++++++++
 tb/tb_reg_file_clr.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the clearing register file.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  localparam int unsigned RF_ZERO_IDX = 0;
  localparam int unsigned RF_A0_IDX   = 10;

endpackage

// File: rtl/reg_file_clr_if.sv
// Decode-stage register file bus: two read ports, one write port, debug tap and busy.
interface reg_file_clr_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0] AD1;
  logic [ADDRESS_WIDTH-1:0] AD2;
  logic [ADDRESS_WIDTH-1:0] AD3;
  logic [DATA_WIDTH-1:0]    WD3;
  logic                     WE3;
  logic [DATA_WIDTH-1:0]    RD1;
  logic [DATA_WIDTH-1:0]    RD2;
  logic [DATA_WIDTH-1:0]    a0;
  logic                     busy;

  // Decoder / datapath side.
  modport master (
    output AD1, AD2, AD3, WD3, WE3,
    input  RD1, RD2, a0, busy
  );

  // Register file side.
  modport slave (
    input  AD1, AD2, AD3, WD3, WE3,
    output RD1, RD2, a0, busy
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: forces zero for x0 and while busy, else optional write bypass.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic                     byp_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     busy,
  input  logic [DATA_WIDTH-1:0]    stored,
  output logic [DATA_WIDTH-1:0]    data
);

  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(RF_ZERO_IDX);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    data = stored;
    if (busy || (addr == ZERO_IDX)) begin
      data = '0;
    end else if (byp_en && (wr_addr == addr)) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/reg_file_clr.sv
// RV32I-style register file with x0 hardwired to zero, optional write bypass,
// a debug tap, and a post-reset sequencer that zeroes one entry per cycle.
module reg_file_clr
  import rf_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 5,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned TAP_ADDR      = RF_A0_IDX,
  parameter int          BYPASS        = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_file_clr_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(RF_ZERO_IDX);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDRESS_WIDTH-1:0] TAP_IDX  = ADDRESS_WIDTH'(TAP_ADDR);

  if (ADDRESS_WIDTH < 1) begin : g_bad_width
    $error("reg_file_clr: ADDRESS_WIDTH must be at least 1");
  end
  if (TAP_ADDR >= DEPTH) begin : g_bad_tap
    $error("reg_file_clr: TAP_ADDR must index an existing entry");
  end

  rf_state_t                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_idx_q, clr_idx_d;

  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic busy;
  logic byp_en;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // The clear walk and normal writes share the single array write port.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_addr  = bus.AD3;
    mem_wdata = bus.WD3;
    unique case (state_q)
      RF_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        mem_we = bus.WE3 && (bus.AD3 != ZERO_IDX);
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
  end

  // NOTE: the array has no reset branch; the clear sequencer zeroes it, keeping it a plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign busy     = (state_q == RF_CLEAR) || !rst_n;
  assign byp_en   = (BYPASS != 0) && (state_q == RF_RUN) && bus.WE3;
  assign bus.busy = busy;

  // The tap shows committed contents only; a same-cycle write appears next cycle.
  assign bus.a0 = (busy || (TAP_IDX == ZERO_IDX)) ? '0 : mem[TAP_IDX];

  rf_read_port #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_rd1 (
    .addr    (bus.AD1),
    .byp_en  (byp_en),
    .wr_addr (bus.AD3),
    .wr_data (bus.WD3),
    .busy    (busy),
    .stored  (mem[bus.AD1]),
    .data    (bus.RD1)
  );

  rf_read_port #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_rd2 (
    .addr    (bus.AD2),
    .byp_en  (byp_en),
    .wr_addr (bus.AD3),
    .wr_data (bus.WD3),
    .busy    (busy),
    .stored  (mem[bus.AD2]),
    .data    (bus.RD2)
  );

endmodule

// File: tb/tb_reg_file_clr.sv
// Scoreboard bench: one bypassing and one non-bypassing register file driven with identical stimulus.
module tb_reg_file_clr;
  import rf_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  reg_file_clr_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();
  reg_file_clr_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_n ();

  reg_file_clr #(
    .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .TAP_ADDR (RF_A0_IDX), .BYPASS (1)
  ) u_byp (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  reg_file_clr #(
    .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .TAP_ADDR (RF_A0_IDX), .BYPASS (0)
  ) u_nob (
    .clk (clk), .rst_n (rst_n), .bus (bus_n)
  );

  typedef struct {
    string          tag;
    logic [DW-1:0]  rd1_b;
    logic [DW-1:0]  rd2_b;
    logic [DW-1:0]  rd1_n;
    logic [DW-1:0]  rd2_n;
    logic [DW-1:0]  a0;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [AW-1:0] ad1, input logic [AW-1:0] ad2,
                       input logic [AW-1:0] ad3, input logic [DW-1:0] wd3, input logic we3);
    bus_b.AD1 = ad1; bus_b.AD2 = ad2; bus_b.AD3 = ad3; bus_b.WD3 = wd3; bus_b.WE3 = we3;
    bus_n.AD1 = ad1; bus_n.AD2 = ad2; bus_n.AD3 = ad3; bus_n.WD3 = wd3; bus_n.WE3 = we3;
  endtask

  function automatic logic [DW-1:0] stored_val(input logic [AW-1:0] ad);
    return (ad == 0) ? '0 : model[ad];
  endfunction

  // One RUN-mode cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input string tag, input logic [AW-1:0] ad1, input logic [AW-1:0] ad2,
                       input logic [AW-1:0] ad3, input logic [DW-1:0] wd3, input logic we3);
    exp_t e;
    drive(ad1, ad2, ad3, wd3, we3);
    e.tag   = tag;
    e.rd1_n = stored_val(ad1);
    e.rd2_n = stored_val(ad2);
    e.rd1_b = (we3 && ad3 == ad1 && ad1 != 0) ? wd3 : e.rd1_n;
    e.rd2_b = (we3 && ad3 == ad2 && ad2 != 0) ? wd3 : e.rd2_n;
    e.a0    = model[RF_A0_IDX];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (we3 && ad3 != 0) model[ad3] = wd3;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".rd1_byp"}, bus_b.RD1, e.rd1_b);
      check({e.tag, ".rd2_byp"}, bus_b.RD2, e.rd2_b);
      check({e.tag, ".rd1_nob"}, bus_n.RD1, e.rd1_n);
      check({e.tag, ".rd2_nob"}, bus_n.RD2, e.rd2_n);
      check({e.tag, ".a0_byp"},  bus_b.a0,  e.a0);
      check({e.tag, ".a0_nob"},  bus_n.a0,  e.a0);
      check({e.tag, ".busy"},    {31'b0, bus_b.busy | bus_n.busy}, '0);
    end
  end

  task automatic check_busy_zero(input string tag);
    check({tag, ".busy_byp"}, {31'b0, bus_b.busy}, 32'd1);
    check({tag, ".busy_nob"}, {31'b0, bus_n.busy}, 32'd1);
    check({tag, ".rd1"},      bus_b.RD1 | bus_n.RD1, '0);
    check({tag, ".rd2"},      bus_b.RD2 | bus_n.RD2, '0);
    check({tag, ".a0"},       bus_b.a0 | bus_n.a0, '0);
  endtask

  // Hold reset, release, and count edges until busy falls. Optionally pushes a
  // write while busy and/or pulses reset once mid-clear.
  task automatic run_clear(input string tag, input int hold, input int inject_at, input int glitch_at);
    int n;
    bit glitched;
    glitched = 1'b0;
    rst_n = 1'b0;
    drive(5, 3, 0, '0, 1'b0);
    repeat (hold) begin
      @(negedge clk);
      check_busy_zero({tag, ".rst"});
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    n = 0;
    while (n < 100) begin
      if (n == inject_at) drive(5, 3, 7, 32'h0000_AAAA, 1'b1);
      else                drive(5, 3, 0, '0, 1'b0);
      @(negedge clk);
      check({tag, ".busy_match"}, {31'b0, bus_n.busy}, {31'b0, bus_b.busy});
      if (!bus_b.busy) break;
      check_busy_zero({tag, ".clr"});
      @(posedge clk);
      #1;
      n++;
      if (!glitched && n == glitch_at) begin
        rst_n = 1'b0;
        drive(5, 3, 0, '0, 1'b0);
        @(negedge clk);
        check_busy_zero({tag, ".glitch"});
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        n        = 0;
        glitched = 1'b1;
      end
    end
    check({tag, ".len"}, n, 32'd32);
    drive(0, 0, 0, '0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, '0, 1'b0);
    @(posedge clk);
    #1;

    run_clear("clr1", 3, 10, -1);
    for (int i = 0; i < DEPTH; i++) cycle("zero1", AW'(i), AW'(DEPTH - 1 - i), 0, '0, 1'b0);
    cycle("x7_after_busy_wr", 7, 7, 0, '0, 1'b0);

    cycle("wr_x5", 5, 5, 5, 32'hDEAD_BEEF, 1'b1);
    cycle("rd_x5", 5, 0, 0, '0, 1'b0);

    cycle("wr_x0", 0, 0, 0, 32'h1234_5678, 1'b1);
    cycle("rd_x0", 0, 0, 0, '0, 1'b0);

    cycle("wr_x10", 10, 11, 10, 32'h0000_00FF, 1'b1);
    cycle("rd_x10", 10, 0, 0, '0, 1'b0);
    cycle("wr_x11", 11, 10, 11, 32'h0000_1111, 1'b1);
    cycle("rd_x11", 11, 10, 0, '0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      cycle("rand", AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
            AW'($urandom_range(0, DEPTH - 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    cycle("wr_x3", 3, 3, 3, 32'h0000_0055, 1'b1);
    cycle("rd_x3", 3, 5, 0, '0, 1'b0);

    run_clear("clr2", 1, -1, 12);
    for (int i = 0; i < DEPTH; i++) cycle("zero2", AW'(i), 3, 0, '0, 1'b0);

    @(negedge clk);
    check("sb_drained", sb.size(), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
